reaction_test_ctrl: RTL and testbench

//  FSM that sequences one reaction-time trial around random_wait.
//  On start it pulses start_wait and waits for rwait_done. It then lights the stimulus LED
//  and counts cycles until react. It reports the reaction time, an early press or a timeout,
//  and tracks the best (minimum) valid time and a trial count. Sits between debounced

---
 rtl/reaction_pkg.sv | 29 ++
 rtl/rt_counter.sv | 37 +++
 rtl/reaction_test_ctrl.sv | 139 +++++++++++++
 tb/tb_reaction_test_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and defaults for the reaction-time trial controller.
// The state encoding is also decoded by the top level to produce its outputs.
package reaction_pkg;

  localparam int DEF_TIME_W      = 14;
  localparam int DEF_TIMEOUT_CYC = 8191;
  localparam int DEF_TRIAL_W     = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    WAIT  = 3'd2,
    GO    = 3'd3,
    DONE  = 3'd4,
    EARLY = 3'd5,
    TOUT  = 3'd6
  } state_t;

  // True for the three states that end a trial and hold a result flag.
  function automatic logic is_result(input state_t s);
    logic r;
    case (s)
      DONE, EARLY, TOUT: r = 1'b1;
      default:           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rt_counter.sv
// Reaction-time cycle counter: synchronous clear, count enable, and a flag
// raised on the last cycle before timeout. The count stops at that value.
module rt_counter
  import reaction_pkg::*;
#(
  parameter int TIME_W      = DEF_TIME_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [TIME_W-1:0] cnt,
  output logic              term
);

  localparam logic [TIME_W-1:0] TERM_VAL = TIME_W'(TIMEOUT_CYC - 1);

  logic [TIME_W-1:0] cnt_r;

  // Cycle counter; holds at the terminal value rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {TIME_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {TIME_W{1'b0}};
    end else if (en && (cnt_r != TERM_VAL)) begin
      cnt_r <= cnt_r + TIME_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign term = (cnt_r == TERM_VAL);

endmodule

// File: rtl/reaction_test_ctrl.sv
// Sequences one reaction-time trial around an external random wait and keeps
// the last reaction time, the best valid time and a saturating trial count.
module reaction_test_ctrl
  import reaction_pkg::*;
#(
  parameter int TIME_W      = DEF_TIME_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TRIAL_W     = DEF_TRIAL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               react,
  input  logic               clr_best,
  input  logic               rwait_done,
  output logic               start_wait,
  output logic               led_on,
  output logic               busy,
  output logic               result_valid,
  output logic               early,
  output logic               timeout,
  output logic [TIME_W-1:0]  rtime,
  output logic [TIME_W-1:0]  best_time,
  output logic [TRIAL_W-1:0] trials
);

  state_t             state_r;
  state_t             next_s;
  logic               done_entry_s;
  logic               result_entry_s;
  logic [TIME_W-1:0]  cnt_s;
  logic               term_s;
  logic [TIME_W-1:0]  rtime_r;
  logic [TIME_W-1:0]  best_r;
  logic [TRIAL_W-1:0] trials_r;

  // The counter is held at zero outside GO, so it reads 0 on the first GO cycle.
  rt_counter #(
    .TIME_W      (TIME_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_r != GO),
    .en   (state_r == GO),
    .cnt  (cnt_s),
    .term (term_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; react beats rwait_done in WAIT and beats timeout in GO.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_s = ARM;
        else       next_s = IDLE;
      end
      ARM: begin
        next_s = WAIT;
      end
      WAIT: begin
        if (react)           next_s = EARLY;
        else if (rwait_done) next_s = GO;
        else                 next_s = WAIT;
      end
      GO: begin
        if (react)       next_s = DONE;
        else if (term_s) next_s = TOUT;
        else             next_s = GO;
      end
      DONE, EARLY, TOUT: begin
        if (start) next_s = ARM;
        else       next_s = state_r;
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // Result-entry strobes for the statistics registers.
  always_comb begin
    done_entry_s   = (state_r == GO) && react;
    result_entry_s = is_result(next_s) && !is_result(state_r);
  end

  // Last valid reaction time; early presses and timeouts leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rtime_r <= {TIME_W{1'b0}};
    end else if (done_entry_s) begin
      rtime_r <= cnt_s;
    end else begin
      rtime_r <= rtime_r;
    end
  end

  // Best time and trial count; a clear request overrides a same-cycle update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_r   <= {TIME_W{1'b1}};
      trials_r <= {TRIAL_W{1'b0}};
    end else if (clr_best) begin
      best_r   <= {TIME_W{1'b1}};
      trials_r <= {TRIAL_W{1'b0}};
    end else begin
      if (done_entry_s && (cnt_s < best_r)) begin
        best_r <= cnt_s;
      end else begin
        best_r <= best_r;
      end
      if (result_entry_s && (trials_r != {TRIAL_W{1'b1}})) begin
        trials_r <= trials_r + TRIAL_W'(1);
      end else begin
        trials_r <= trials_r;
      end
    end
  end

  assign start_wait   = (state_r == ARM);
  assign led_on       = (state_r == GO);
  assign busy         = (state_r == ARM) || (state_r == WAIT) || (state_r == GO);
  assign result_valid = (state_r == DONE);
  assign early        = (state_r == EARLY);
  assign timeout      = (state_r == TOUT);
  assign rtime        = rtime_r;
  assign best_time    = best_r;
  assign trials       = trials_r;

endmodule

// File: tb/tb_reaction_test_ctrl.sv
// Scoreboard bench for reaction_test_ctrl: trial tasks push expected results,
// a negedge monitor pops and compares whenever a result flag rises.
module tb_reaction_test_ctrl;

  localparam int TIME_W      = 14;
  localparam int TIMEOUT_CYC = 8191;
  localparam int TRIAL_W     = 8;
  localparam int BEST_INIT   = 16383;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, react = 1'b0, clr_best = 1'b0, rwait_done = 1'b0;
  logic start_wait, led_on, busy, result_valid, early, timeout;
  logic [TIME_W-1:0]  rtime, best_time;
  logic [TRIAL_W-1:0] trials;

  typedef struct {
    int kind;    // 0 DONE, 1 EARLY, 2 TOUT
    int rtime;
    int best;
    int trials;
  } exp_t;

  exp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;
  int m_rtime = 0, m_best = BEST_INIT, m_trials = 0;
  logic [2:0] prev_flags = 3'b000;

  reaction_test_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .react        (react),
    .clr_best     (clr_best),
    .rwait_done   (rwait_done),
    .start_wait   (start_wait),
    .led_on       (led_on),
    .busy         (busy),
    .result_valid (result_valid),
    .early        (early),
    .timeout      (timeout),
    .rtime        (rtime),
    .best_time    (best_time),
    .trials       (trials)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the statistics registers for one trial outcome.
  task automatic push_exp(input int kind, input int n, input bit clr);
    exp_t e;
    if (kind == 0) m_rtime = n;
    if (clr) begin
      m_best   = BEST_INIT;
      m_trials = 0;
    end else begin
      if (kind == 0 && n < m_best) m_best = n;
      if (m_trials < 255) m_trials++;
    end
    e.kind = kind; e.rtime = m_rtime; e.best = m_best; e.trials = m_trials;
    sb_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_start_wait"}, start_wait, 0);
    chk({tag, "_led_on"}, led_on, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_early"}, early, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_rtime"}, rtime, 0);
    chk({tag, "_best_time"}, best_time, BEST_INIT);
    chk({tag, "_trials"}, trials, 0);
  endtask

  // start -> ARM -> WAIT, wait, rwait_done -> GO, react at cnt == n.
  task automatic do_trial(input int wait_cyc, input int n, input bit clr);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    repeat (wait_cyc) tick();
    rwait_done = 1'b1; tick(); rwait_done = 1'b0;
    repeat (n) tick();
    push_exp(0, n, clr);
    react = 1'b1; clr_best = clr; tick(); react = 1'b0; clr_best = 1'b0;
  endtask

  // react while still waiting, optionally on the same cycle as rwait_done.
  task automatic early_trial(input bit coinc);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    repeat (3) tick();
    push_exp(1, 0, 1'b0);
    react = 1'b1; rwait_done = coinc; tick(); react = 1'b0; rwait_done = 1'b0;
    chk("early_led_off", led_on, 0);
    tick();
    chk("early_led_still_off", led_on, 0);
  endtask

  // Monitor: each rising result flag consumes one scoreboard entry.
  always @(negedge clk) begin : monitor
    logic [2:0] f;
    exp_t e;
    int kind_act;
    f = {timeout, early, result_valid};
    if (rst && f != 3'b000 && prev_flags == 3'b000) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: flags %b with nothing expected", f);
      end else begin
        e = sb_q.pop_front();
        kind_act = (f == 3'b001) ? 0 : (f == 3'b010) ? 1 : (f == 3'b100) ? 2 : 3;
        chk("result_kind", kind_act, e.kind);
        chk("result_rtime", rtime, e.rtime);
        chk("result_best", best_time, e.best);
        chk("result_trials", trials, e.trials);
      end
    end
    prev_flags <= f;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    #2 rst = 1'b0;
    repeat (3) tick();
    check_reset("por");
    rst = 1'b1;
    tick();

    // Basic trials and best-time tracking.
    do_trial(3000, 250, 1'b0);
    do_trial(20, 400, 1'b0);
    do_trial(20, 100, 1'b0);

    // Early presses, plain and coincident with rwait_done.
    early_trial(1'b0);
    early_trial(1'b1);

    // Timeout latency measured from the led_on rise.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    repeat (10) tick();
    rwait_done = 1'b1; tick(); rwait_done = 1'b0;
    chk("go_led_on", led_on, 1);
    push_exp(2, 0, 1'b0);
    cnt = 0;
    while (!timeout && cnt < 9000) begin
      tick();
      cnt++;
    end
    chk("timeout_latency", cnt, TIMEOUT_CYC);

    // React on the very last GO cycle beats the timeout.
    do_trial(10, TIMEOUT_CYC - 1, 1'b0);

    // start_wait width and start ignored in WAIT/GO, then reset during GO.
    start = 1'b1; tick(); start = 1'b0;
    chk("arm_start_wait", start_wait, 1);
    tick();
    chk("wait_start_wait_low", start_wait, 0);
    chk("wait_busy", busy, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("wait_start_ignored", start_wait, 0);
    chk("wait_busy_hold", busy, 1);
    rwait_done = 1'b1; tick(); rwait_done = 1'b0;
    chk("go2_led_on", led_on, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("go_start_ignored_led", led_on, 1);
    chk("go_start_ignored_arm", start_wait, 0);
    repeat (20) tick();
    rst = 1'b0;
    #1;
    check_reset("midgo");
    m_rtime = 0; m_best = BEST_INIT; m_trials = 0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("post_rst_idle_busy", busy, 0);
    chk("post_rst_no_rearm", start_wait, 0);

    // clr_best coincident with a DONE update, then trial-count saturation.
    do_trial(5, 77, 1'b0);
    do_trial(5, 60, 1'b1);
    for (int i = 0; i < 300; i++) early_trial(1'b0);
    chk("trials_saturated", trials, 255);

    repeat (5) tick();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
